// File: rtl/alu_control_immgen_pkg.sv
// Shared opcode constants, select encodings and the decoded-output record for the
// RV32I control/immediate/ALU stage.
package alu_control_immgen_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  typedef enum logic [4:0] {
    AluAdd   = 5'd0,
    AluSub   = 5'd1,
    AluAnd   = 5'd2,
    AluOr    = 5'd3,
    AluXor   = 5'd4,
    AluSll   = 5'd5,
    AluSrl   = 5'd6,
    AluSra   = 5'd7,
    AluSlt   = 5'd8,
    AluSltu  = 5'd9,
    AluPassB = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {OrigARs1 = 2'd0, OrigAPc = 2'd1, OrigAZero = 2'd2} orig_a_e;
  typedef enum logic [1:0] {OrigBRs2 = 2'd0, OrigBImm = 2'd1, OrigBFour = 2'd2} orig_b_e;
  typedef enum logic [2:0] {WbAlu = 3'd0, WbMem = 3'd1, WbPc4 = 3'd2, WbCsr = 3'd3} mem2reg_e;
  typedef enum logic [2:0] {
    PcPlus4  = 3'd0,
    PcBranch = 3'd1,
    PcJal    = 3'd2,
    PcJalr   = 3'd3,
    PcTrap   = 3'd4
  } orig_pc_e;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  typedef struct packed {
    orig_a_e     orig_a;
    orig_b_e     orig_b;
    logic        reg_write;
    logic        csr_write;
    logic        mem_write;
    logic        mem_read;
    logic        inv;
    logic        ecall;
    logic        ebreak;
    mem2reg_e    mem2reg;
    orig_pc_e    orig_pc;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        zero;
  } stage_out_t;

  // funct3 plus the instr[30] alternate bit select the R/I-type ALU operation.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    unique case (funct3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_immgen_alu_core.sv
// Combinational ALU: wrapping add/sub, logic ops, 5-bit shifts and set-less-than.
module alu_core
  import alu_control_immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:   result_o = a_i + b_i;
      AluSub:   result_o = a_i - b_i;
      AluAnd:   result_o = a_i & b_i;
      AluOr:    result_o = a_i | b_i;
      AluXor:   result_o = a_i ^ b_i;
      AluSll:   result_o = a_i << shamt;
      AluSrl:   result_o = a_i >> shamt;
      AluSra:   result_o = $signed(a_i) >>> shamt;
      AluSlt:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluSltu:  result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      AluPassB: result_o = b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_control_immgen.sv
// RV32I decode, immediate generation and ALU evaluation, all registered with
// one cycle of latency; outputs clear asynchronously while reset is low.
module alu_control_immgen
  import alu_control_immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clockCPU,
  input  logic            reset,
  input  logic [31:0]     iInstr,
  input  logic [XLEN-1:0] iPC,
  input  logic [XLEN-1:0] iRead1,
  input  logic [XLEN-1:0] iRead2,
  output logic [1:0]      oOrigAULA,
  output logic [1:0]      oOrigBULA,
  output logic            oRegWrite,
  output logic            oCSRegWrite,
  output logic            oMemWrite,
  output logic            oMemRead,
  output logic            oInvInstruction,
  output logic            oEcall,
  output logic            oEbreak,
  output logic [2:0]      oMem2Reg,
  output logic [2:0]      oOrigPC,
  output logic [4:0]      oALUControl,
  output logic [XLEN-1:0] oImm,
  output logic [XLEN-1:0] oALUresult,
  output logic            oZero
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];

  stage_out_t      out_d, out_q;
  imm_fmt_e        imm_fmt;
  logic            illegal;
  logic            br_taken;
  logic [XLEN-1:0] imm, alu_a, alu_b, alu_result;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (iRead1 == iRead2);
      3'b001:  br_taken = (iRead1 != iRead2);
      3'b100:  br_taken = ($signed(iRead1) < $signed(iRead2));
      3'b101:  br_taken = ($signed(iRead1) >= $signed(iRead2));
      3'b110:  br_taken = (iRead1 < iRead2);
      3'b111:  br_taken = (iRead1 >= iRead2);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    out_d   = '0;
    imm_fmt = ImmNone;
    illegal = 1'b0;
    out_d.orig_a  = OrigARs1;
    out_d.orig_b  = OrigBRs2;
    out_d.mem2reg = WbAlu;
    out_d.orig_pc = PcPlus4;
    out_d.alu_op  = AluAdd;
    case (opcode)
      OpLui: begin
        imm_fmt = ImmU;
        out_d.reg_write = 1'b1;
        out_d.orig_a    = OrigAZero;
        out_d.orig_b    = OrigBImm;
      end
      OpAuipc: begin
        imm_fmt = ImmU;
        out_d.reg_write = 1'b1;
        out_d.orig_a    = OrigAPc;
        out_d.orig_b    = OrigBImm;
      end
      OpJal: begin
        imm_fmt = ImmJ;
        out_d.reg_write = 1'b1;
        out_d.orig_a    = OrigAPc;
        out_d.orig_b    = OrigBImm;
        out_d.mem2reg   = WbPc4;
        out_d.orig_pc   = PcJal;
      end
      OpJalr: begin
        imm_fmt = ImmI;
        illegal = (funct3 != 3'b000);
        out_d.reg_write = 1'b1;
        out_d.orig_b    = OrigBImm;
        out_d.mem2reg   = WbPc4;
        out_d.orig_pc   = PcJalr;
      end
      OpBranch: begin
        imm_fmt = ImmB;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
        // ALU op mirrors the comparison kind; the taken decision is made separately.
        out_d.alu_op  = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
        out_d.orig_pc = br_taken ? PcBranch : PcPlus4;
      end
      OpLoad: begin
        imm_fmt = ImmI;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        out_d.reg_write = 1'b1;
        out_d.mem_read  = 1'b1;
        out_d.orig_b    = OrigBImm;
        out_d.mem2reg   = WbMem;
      end
      OpStore: begin
        imm_fmt = ImmS;
        illegal = (funct3[2] == 1'b1) || (funct3 == 3'b011);
        out_d.mem_write = 1'b1;
        out_d.orig_b    = OrigBImm;
      end
      OpImm: begin
        imm_fmt = ImmI;
        illegal = ((funct3 == 3'b001) && (funct7 != 7'b0)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != 7'b0100000));
        out_d.reg_write = 1'b1;
        out_d.orig_b    = OrigBImm;
        out_d.alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && iInstr[30]);
      end
      OpReg: begin
        illegal = !((funct7 == 7'b0) || ((funct7 == 7'b0100000) &&
                    ((funct3 == 3'b000) || (funct3 == 3'b101))));
        out_d.reg_write = 1'b1;
        out_d.alu_op    = alu_from_funct(funct3, iInstr[30]);
      end
      OpSystem: begin
        imm_fmt = ImmI;
        if (funct3 == 3'b000) begin
          if (iInstr == InstrEcall) begin
            out_d.ecall   = 1'b1;
            out_d.orig_pc = PcTrap;
          end else if (iInstr == InstrEbreak) begin
            out_d.ebreak  = 1'b1;
            out_d.orig_pc = PcTrap;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct3[2] == 1'b0) begin
          out_d.reg_write = 1'b1;
          out_d.csr_write = 1'b1;
          out_d.mem2reg   = WbCsr;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      out_d         = '0;
      imm_fmt       = ImmNone;
      out_d.inv     = 1'b1;
      out_d.orig_pc = PcTrap;
    end
  end

  always_comb begin
    imm = '0;
    case (imm_fmt)
      ImmI:    imm = {{20{iInstr[31]}}, iInstr[31:20]};
      ImmS:    imm = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
      ImmB:    imm = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
      ImmU:    imm = {iInstr[31:12], 12'b0};
      ImmJ:    imm = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21],
                      1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    alu_a = iRead1;
    case (out_d.orig_a)
      OrigAPc:   alu_a = iPC;
      OrigAZero: alu_a = '0;
      default:   alu_a = iRead1;
    endcase
    alu_b = iRead2;
    case (out_d.orig_b)
      OrigBImm:  alu_b = imm;
      OrigBFour: alu_b = 32'd4;
      default:   alu_b = iRead2;
    endcase
  end

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (out_d.alu_op),
    .result_o (alu_result)
  );

  stage_out_t stage_d;
  always_comb begin
    stage_d            = out_d;
    stage_d.imm        = imm;
    stage_d.alu_result = alu_result;
    stage_d.zero       = (alu_result == '0);
  end

  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= stage_d;
    end
  end

  assign oOrigAULA       = out_q.orig_a;
  assign oOrigBULA       = out_q.orig_b;
  assign oRegWrite       = out_q.reg_write;
  assign oCSRegWrite     = out_q.csr_write;
  assign oMemWrite       = out_q.mem_write;
  assign oMemRead        = out_q.mem_read;
  assign oInvInstruction = out_q.inv;
  assign oEcall          = out_q.ecall;
  assign oEbreak         = out_q.ebreak;
  assign oMem2Reg        = out_q.mem2reg;
  assign oOrigPC         = out_q.orig_pc;
  assign oALUControl     = out_q.alu_op;
  assign oImm            = out_q.imm;
  assign oALUresult      = out_q.alu_result;
  assign oZero           = out_q.zero;

endmodule

// File: tb/tb_alu_control_immgen.sv
// Directed vector table for the decode/imm/ALU stage plus reset and latency sequences.
module tb_alu_control_immgen;

  logic        clockCPU = 1'b0;
  logic        reset;
  logic [31:0] iInstr, iPC, iRead1, iRead2;
  logic [1:0]  oOrigAULA, oOrigBULA;
  logic        oRegWrite, oCSRegWrite, oMemWrite, oMemRead, oInvInstruction, oEcall, oEbreak;
  logic [2:0]  oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;
  logic [31:0] oImm, oALUresult;
  logic        oZero;

  always #5 clockCPU = ~clockCPU;

  alu_control_immgen #(
    .XLEN(32)
  ) dut (
    .clockCPU        (clockCPU),
    .reset           (reset),
    .iInstr          (iInstr),
    .iPC             (iPC),
    .iRead1          (iRead1),
    .iRead2          (iRead2),
    .oOrigAULA       (oOrigAULA),
    .oOrigBULA       (oOrigBULA),
    .oRegWrite       (oRegWrite),
    .oCSRegWrite     (oCSRegWrite),
    .oMemWrite       (oMemWrite),
    .oMemRead        (oMemRead),
    .oInvInstruction (oInvInstruction),
    .oEcall          (oEcall),
    .oEbreak         (oEbreak),
    .oMem2Reg        (oMem2Reg),
    .oOrigPC         (oOrigPC),
    .oALUControl     (oALUControl),
    .oImm            (oImm),
    .oALUresult      (oALUresult),
    .oZero           (oZero)
  );

  // full=0 skips the ALU-path fields whose values are not defined for that instruction.
  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic        full;
    logic [1:0]  a, b;
    logic [6:0]  fl;  // {regw, csrw, memw, memr, inv, ecall, ebreak}
    logic [2:0]  wb, npc;
    logic [4:0]  alu;
    logic [31:0] imm, res;
    logic        zero;
  } vec_t;

  int nchk = 0;
  int nerr = 0;
  vec_t vq[$];

  function automatic vec_t mk(input logic [31:0] instr, pc, r1, r2, input logic full,
                              input logic [1:0] a, b, input logic [6:0] fl,
                              input logic [2:0] wb, npc, input logic [4:0] alu,
                              input logic [31:0] imm, res, input logic zero);
    vec_t v;
    v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2; v.full = full;
    v.a = a; v.b = b; v.fl = fl; v.wb = wb; v.npc = npc; v.alu = alu;
    v.imm = imm; v.res = res; v.zero = zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc, r1, r2);
    iInstr = instr; iPC = pc; iRead1 = r1; iRead2 = r2;
  endtask

  logic [6:0] flags;
  assign flags = {oRegWrite, oCSRegWrite, oMemWrite, oMemRead, oInvInstruction, oEcall, oEbreak};

  logic any_out;
  assign any_out = |{oOrigAULA, oOrigBULA, flags, oMem2Reg, oOrigPC, oALUControl, oImm,
                     oALUresult, oZero};

  initial begin
    //                 instr          pc      r1            r2        f  a  b  flags      wb npc alu
    vq.push_back(mk(32'hFFB00093, 0,     0,            0,        1, 0, 1, 7'b1000000, 0, 0, 0,
                    32'hFFFFFFFB, 32'hFFFFFFFB, 0));
    vq.push_back(mk(32'h40208033, 0,     3,            5,        1, 0, 0, 7'b1000000, 0, 0, 1,
                    0, 32'hFFFFFFFE, 0));
    vq.push_back(mk(32'h00208463, 0,     7,            7,        1, 0, 0, 7'b0000000, 0, 1, 1,
                    8, 0, 1));
    vq.push_back(mk(32'h00208463, 0,     7,            6,        1, 0, 0, 7'b0000000, 0, 0, 1,
                    8, 1, 0));
    vq.push_back(mk(32'h4040D093, 0,     32'h80000000, 0,        1, 0, 1, 7'b1000000, 0, 0, 7,
                    32'h404, 32'hF8000000, 0));
    vq.push_back(mk(32'h0040D093, 0,     32'h80000000, 0,        1, 0, 1, 7'b1000000, 0, 0, 6,
                    4, 32'h08000000, 0));
    vq.push_back(mk(32'hFFFFFFFF, 0,     0,            0,        0, 0, 0, 7'b0000100, 0, 4, 0,
                    0, 0, 0));
    vq.push_back(mk(32'h00000073, 0,     0,            0,        0, 0, 0, 7'b0000010, 0, 4, 0,
                    0, 0, 0));
    vq.push_back(mk(32'h123452B7, 0,     99,           0,        1, 2, 1, 7'b1000000, 0, 0, 0,
                    32'h12345000, 32'h12345000, 0));
    vq.push_back(mk(32'h00001297, 32'h100, 0,          0,        1, 1, 1, 7'b1000000, 0, 0, 0,
                    32'h1000, 32'h1100, 0));
    vq.push_back(mk(32'h00812083, 0,     32'h1000,     0,        1, 0, 1, 7'b1001000, 1, 0, 0,
                    8, 32'h1008, 0));
    vq.push_back(mk(32'h0020A623, 0,     32'h2000,     32'h55,   1, 0, 1, 7'b0010000, 0, 0, 0,
                    32'hC, 32'h200C, 0));
    vq.push_back(mk(32'hFFDFF0EF, 32'h200, 0,          0,        1, 1, 1, 7'b1000000, 2, 2, 0,
                    32'hFFFFFFFC, 32'h1FC, 0));
    vq.push_back(mk(32'h000280E7, 0,     32'h300,      0,        1, 0, 1, 7'b1000000, 2, 3, 0,
                    0, 32'h300, 0));
    vq.push_back(mk(32'h0020C463, 0,     32'hFFFFFFFF, 1,        1, 0, 0, 7'b0000000, 0, 1, 8,
                    8, 1, 0));
    vq.push_back(mk(32'h0020E463, 0,     32'hFFFFFFFF, 1,        1, 0, 0, 7'b0000000, 0, 0, 9,
                    8, 0, 1));
    vq.push_back(mk(32'h300110F3, 0,     0,            0,        0, 0, 0, 7'b1100000, 3, 0, 0,
                    32'h300, 0, 0));
    vq.push_back(mk(32'h00100073, 0,     0,            0,        0, 0, 0, 7'b0000001, 0, 4, 0,
                    1, 0, 0));
    vq.push_back(mk(32'h00000000, 0,     0,            0,        0, 0, 0, 7'b0000100, 0, 4, 0,
                    0, 0, 0));
    vq.push_back(mk(32'h02208033, 0,     1,            2,        0, 0, 0, 7'b0000100, 0, 4, 0,
                    0, 0, 0));
    vq.push_back(mk(32'h0020F1B3, 0,     32'hF0F0,     32'hFF00, 1, 0, 0, 7'b1000000, 0, 0, 2,
                    0, 32'hF000, 0));
    vq.push_back(mk(32'h002091B3, 0,     1,            32'h24,   1, 0, 0, 7'b1000000, 0, 0, 5,
                    0, 32'h10, 0));
    vq.push_back(mk(32'hFFF0B093, 0,     5,            0,        1, 0, 1, 7'b1000000, 0, 0, 9,
                    32'hFFFFFFFF, 1, 0));

    // Reset state, before and across clock edges.
    reset = 1'b0;
    drive(32'hFFB00093, 0, 0, 0);
    #3;
    chk("reset_async_any", {31'b0, any_out}, 0);
    repeat (2) @(posedge clockCPU);
    #1;
    chk("reset_held_any", {31'b0, any_out}, 0);
    chk("reset_held_zero", {31'b0, oZero}, 0);
    @(negedge clockCPU);
    reset = 1'b1;

    foreach (vq[i]) begin
      @(negedge clockCPU);
      drive(vq[i].instr, vq[i].pc, vq[i].r1, vq[i].r2);
      @(posedge clockCPU);
      #1;
      chk($sformatf("v%0d flags", i), {25'b0, flags}, {25'b0, vq[i].fl});
      chk($sformatf("v%0d mem2reg", i), {29'b0, oMem2Reg}, {29'b0, vq[i].wb});
      chk($sformatf("v%0d origpc", i), {29'b0, oOrigPC}, {29'b0, vq[i].npc});
      chk($sformatf("v%0d imm", i), oImm, vq[i].imm);
      if (vq[i].full) begin
        chk($sformatf("v%0d origa", i), {30'b0, oOrigAULA}, {30'b0, vq[i].a});
        chk($sformatf("v%0d origb", i), {30'b0, oOrigBULA}, {30'b0, vq[i].b});
        chk($sformatf("v%0d aluctl", i), {27'b0, oALUControl}, {27'b0, vq[i].alu});
        chk($sformatf("v%0d result", i), oALUresult, vq[i].res);
        chk($sformatf("v%0d zero", i), {31'b0, oZero}, {31'b0, vq[i].zero});
      end
    end

    // Exactly one cycle of latency: an input change alone must not reach the outputs.
    @(negedge clockCPU);
    drive(32'hFFDFF0EF, 32'h200, 0, 0);
    @(posedge clockCPU);
    #1;
    chk("lat_jal_imm", oImm, 32'hFFFFFFFC);
    @(negedge clockCPU);
    drive(32'h40208033, 0, 3, 5);
    #1;
    chk("lat_hold_imm", oImm, 32'hFFFFFFFC);
    chk("lat_hold_pc", {29'b0, oOrigPC}, 2);
    @(posedge clockCPU);
    #1;
    chk("lat_sub_alu", {27'b0, oALUControl}, 1);
    chk("lat_sub_res", oALUresult, 32'hFFFFFFFE);

    // Mid-stream reset: outputs clear before the next edge, in-flight work is dropped.
    @(negedge clockCPU);
    drive(32'h00208463, 0, 7, 7);
    @(posedge clockCPU);
    #1;
    chk("pre_rst_zero", {31'b0, oZero}, 1);
    #1;
    reset = 1'b0;
    drive(32'h123452B7, 0, 99, 0);
    #1;
    chk("mid_rst_any", {31'b0, any_out}, 0);
    chk("mid_rst_zero", {31'b0, oZero}, 0);
    @(posedge clockCPU);
    #1;
    chk("mid_rst_edge_any", {31'b0, any_out}, 0);
    @(negedge clockCPU);
    reset = 1'b1;
    #1;
    chk("rel_before_edge", {31'b0, any_out}, 0);
    @(posedge clockCPU);
    #1;
    chk("rel_lui_imm", oImm, 32'h12345000);
    chk("rel_lui_res", oALUresult, 32'h12345000);
    chk("rel_lui_regw", {31'b0, oRegWrite}, 1);
    chk("rel_lui_origa", {30'b0, oOrigAULA}, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_control_immgen.md
ALU_CONTROL_IMMGEN -- requirements
Module: alu_control_immgen

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clockCPU, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port iInstr, input, 32 bits: RV32I instruction word.
REQ-005 SHALL have port iPC, input, 32 bits: address of iInstr.
REQ-006 SHALL have port iRead1, input, 32 bits: rs1 register value.
REQ-007 SHALL have port iRead2, input, 32 bits: rs2 register value.
REQ-008 SHALL have port oOrigAULA, output, 2 bits: ALU A select; 0=rs1, 1=PC, 2=zero.
REQ-009 SHALL have port oOrigBULA, output, 2 bits: ALU B select; 0=rs2, 1=imm, 2=constant 4.
REQ-010 SHALL have ports oRegWrite, oCSRegWrite, oMemWrite, oMemRead, oInvInstruction, oEcall and oEbreak, each output, 1 bit, as named.
REQ-011 SHALL have port oMem2Reg, output, 3 bits: writeback select; 0=ALU, 1=memory, 2=PC+4, 3=CSR.
REQ-012 SHALL have port oOrigPC, output, 3 bits: next-PC select; 0=PC+4, 1=branch target, 2=JAL target, 3=JALR target, 4=trap.
REQ-013 SHALL have port oALUControl, output, 5 bits: ALU op code.
REQ-014 SHALL have port oImm, output, 32 bits: sign-extended immediate.
REQ-015 SHALL have port oALUresult, output, 32 bits: ALU result.
REQ-016 SHALL have port oZero, output, 1 bit: asserted when oALUresult==0.

Function
REQ-017 ALU codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS-B; codes 11-31 give result 0.
REQ-018 Shifts SHALL use B[4:0] only; SLT SHALL compare signed, SLTU unsigned; add/sub SHALL wrap modulo 2^32 with no overflow flag.
REQ-019 The immediate SHALL be formed per format: I (loads, OP-IMM, JALR, SYSTEM), S, B (bit0=0), U (low 12 bits=0) and J (bit0=0), all sign-extended from instr[31]; R-type and invalid instructions SHALL give 0.
REQ-020 Decode SHALL be:
- LUI: A=zero, B=imm, ADD.
- AUIPC: A=PC, B=imm, ADD.
- JAL/JALR: Mem2Reg=2, OrigPC=2/3.
- Loads: MemRead, B=imm, Mem2Reg=1.
- Stores: MemWrite, B=imm, no RegWrite.
- OP/OP-IMM: RegWrite, ALU op from funct3/funct7[5]; instr[30] selects SUB and SRA(I).
- CSRRW/S/C: RegWrite, CSRegWrite, Mem2Reg=3.
- ECALL: oEcall=1, OrigPC=4. EBREAK: oEbreak=1, OrigPC=4.
REQ-021 Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU) SHALL compare iRead1 against iRead2 internally and drive oOrigPC=1 only when taken, else 0; they SHALL have no RegWrite and no memory access.
REQ-022 An unknown opcode, illegal funct3/funct7 combination or the all-zero word SHALL set oInvInstruction=1 with RegWrite, CSRegWrite, MemWrite and MemRead all 0 and OrigPC=4.
REQ-023 Decode, immediate and ALU logic SHALL be combinational from the inputs; every output SHALL be registered, with latency exactly 1 clockCPU cycle.
REQ-024 With no reset, outputs SHALL update every cycle; there is no handshake or stall.

Reset
REQ-025 While reset=0, all outputs SHALL be 0 immediately (asynchronously), including oZero, which is not recomputed during reset.
REQ-026 After reset is released, the first rising edge SHALL register the decode of the current inputs; an instruction in flight when reset is asserted SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold the opcode constants, the ALU code enum, and the OrigA, OrigB, Mem2Reg and OrigPC select enums.
REQ-028 A single sub-module, alu_core, SHALL implement the combinational ALU; decode and immediate logic SHALL stay in the top level.

Verification
REQ-029 addi x1,x0,-5 (0xFFB00093), iRead1=0 -> next cycle oImm=0xFFFFFFFB, oALUresult=0xFFFFFFFB, oRegWrite=1, oOrigBULA=1.
REQ-030 sub x0,x1,x2 (0x40208033), iRead1=3, iRead2=5 -> oALUControl=1, oALUresult=0xFFFFFFFE, oZero=0.
REQ-031 beq x1,x2,+8 (0x00208463): with iRead1=iRead2=7 -> oOrigPC=1, oImm=8; with iRead2=6 -> oOrigPC=0.
REQ-032 srai x1,x1,4 (0x4040D093), iRead1=0x80000000 -> oALUresult=0xF8000000; srli (0x0040D093) -> 0x08000000.
REQ-033 0xFFFFFFFF -> oInvInstruction=1 and all write and read enables 0; ecall (0x00000073) -> oEcall=1, oOrigPC=4.
REQ-034 Assert reset low mid-stream -> all outputs 0 before the next edge; release it -> the first edge shows the decode of the current iInstr.
